// File: rtl/conversion_scheduler_if.sv
// Signal bundle between the conversion scheduler, the MCU side and the dual-slope sequencer.
// The scheduler connects through the slave modport; the environment drives through master.
interface conversion_scheduler_if;
    logic        host_req_i;
    logic        host_ack_o;
    logic        auto_en_i;
    logic [15:0] auto_period_i;
    logic        analog_ready_i;
    logic        idle_i;
    logic        ref_sign_i;
    logic [11:0] measurement_count_i;
    logic        conv_trigger_o;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [11:0] result_o;
    logic        result_sign_o;
    logic        result_src_o;
    logic        overrun_o;
    logic        err_o;
    logic        err_clr_i;

    modport master (
        output host_req_i, auto_en_i, auto_period_i, analog_ready_i, idle_i,
               ref_sign_i, measurement_count_i, result_ready_i, err_clr_i,
        input  host_ack_o, conv_trigger_o, result_valid_o, result_o,
               result_sign_o, result_src_o, overrun_o, err_o
    );

    modport slave (
        input  host_req_i, auto_en_i, auto_period_i, analog_ready_i, idle_i,
               ref_sign_i, measurement_count_i, result_ready_i, err_clr_i,
        output host_ack_o, conv_trigger_o, result_valid_o, result_o,
               result_sign_o, result_src_o, overrun_o, err_o
    );
endinterface

// File: rtl/conversion_scheduler.sv
// Round-robin scheduler for host single-shot and periodic auto conversions on one dual-slope
// sequencer: trigger, start/conversion timeouts, result capture and valid/ready readout.
//
// state      | meaning
// S_IDLE     | waiting for a pending request with AFE ready and sequencer idle
// S_TRIG     | one-cycle trigger pulse, host ack if host was granted
// S_WAIT_ST  | waiting for idle_i to fall (start timeout armed)
// S_WAIT_DN  | waiting for idle_i to rise (conversion timeout armed)
// S_PRESENT  | result valid, held until the consumer accepts it
module conversion_scheduler #(
    parameter int unsigned START_TO = 16,
    parameter int unsigned CONV_TO  = 65535
) (
    input logic                   clk_i,
    input logic                   rst_i,
    conversion_scheduler_if.slave bus
);
    localparam logic [15:0] START_LIM = 16'(START_TO - 1);
    localparam logic [15:0] CONV_LIM  = 16'(CONV_TO - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TRIG    = 3'd1,
        S_WAIT_ST = 3'd2,
        S_WAIT_DN = 3'd3,
        S_PRESENT = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        host_pend_q, host_pend_d;
    logic        auto_pend_q, auto_pend_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_src_q, grant_src_d;
    logic [15:0] period_cnt_q, period_cnt_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [11:0] res_cnt_q, res_cnt_d;
    logic        res_sign_q, res_sign_d;
    logic        res_src_q, res_src_d;
    logic        err_q, err_d;
    logic        overrun_q, overrun_d;

    logic start_ok;
    logic grant_host;
    logic auto_run;
    logic tick;
    logic err_set;

    assign start_ok   = (state_q == S_IDLE) & (host_pend_q | auto_pend_q)
                      & bus.analog_ready_i & bus.idle_i;
    // last_grant_q: 1 = auto, so host wins a tie right after reset
    assign grant_host = host_pend_q & (~auto_pend_q | last_grant_q);
    assign auto_run   = bus.auto_en_i & (bus.auto_period_i != 16'd0);
    assign tick       = auto_run & (period_cnt_q == bus.auto_period_i - 16'd1);
    assign err_set    = ((state_q == S_WAIT_ST) &  bus.idle_i & (tmo_cnt_q == START_LIM))
                      | ((state_q == S_WAIT_DN) & ~bus.idle_i & (tmo_cnt_q == CONV_LIM));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_ok) state_d = S_TRIG;
            S_TRIG:    state_d = S_WAIT_ST;
            S_WAIT_ST: begin
                if (!bus.idle_i)                 state_d = S_WAIT_DN;
                else if (tmo_cnt_q == START_LIM) state_d = S_IDLE;
            end
            S_WAIT_DN: begin
                if (bus.idle_i)                 state_d = S_PRESENT;
                else if (tmo_cnt_q == CONV_LIM) state_d = S_IDLE;
            end
            S_PRESENT: if (bus.result_ready_i) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.conv_trigger_o = 1'b0;
        bus.host_ack_o     = 1'b0;
        bus.result_valid_o = 1'b0;
        case (state_q)
            S_TRIG: begin
                bus.conv_trigger_o = 1'b1;
                bus.host_ack_o     = ~grant_src_q;
            end
            S_PRESENT: bus.result_valid_o = 1'b1;
            default: ;
        endcase
    end

    assign bus.result_o      = res_cnt_q;
    assign bus.result_sign_o = res_sign_q;
    assign bus.result_src_o  = res_src_q;
    assign bus.overrun_o     = overrun_q;
    assign bus.err_o         = err_q;

    always_comb begin
        period_cnt_d = 16'd0;
        if (auto_run && !tick) period_cnt_d = period_cnt_q + 16'd1;

        // a new request in the grant cycle keeps its flag set
        host_pend_d = bus.host_req_i | (host_pend_q & ~(start_ok &  grant_host));
        auto_pend_d = tick           | (auto_pend_q & ~(start_ok & ~grant_host));

        grant_src_d  = start_ok ? ~grant_host : grant_src_q;
        last_grant_d = (state_q == S_TRIG) ? grant_src_q : last_grant_q;

        tmo_cnt_d = tmo_cnt_q;
        case (state_q)
            S_TRIG:    tmo_cnt_d = 16'd0;
            S_WAIT_ST: tmo_cnt_d = bus.idle_i ? tmo_cnt_q + 16'd1 : 16'd0;
            S_WAIT_DN: if (!bus.idle_i) tmo_cnt_d = tmo_cnt_q + 16'd1;
            default: ;
        endcase

        res_cnt_d  = res_cnt_q;
        res_sign_d = res_sign_q;
        res_src_d  = res_src_q;
        if (state_q == S_WAIT_DN && bus.idle_i) begin
            res_cnt_d  = bus.measurement_count_i;
            res_sign_d = bus.ref_sign_i;
            res_src_d  = grant_src_q;
        end

        err_d     = err_set | (err_q & ~bus.err_clr_i);
        overrun_d = (tick & auto_pend_q) | (overrun_q & ~bus.err_clr_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            host_pend_q  <= 1'b0;
            auto_pend_q  <= 1'b0;
            last_grant_q <= 1'b1;
            grant_src_q  <= 1'b0;
            period_cnt_q <= 16'd0;
            tmo_cnt_q    <= 16'd0;
            res_cnt_q    <= 12'd0;
            res_sign_q   <= 1'b0;
            res_src_q    <= 1'b0;
            err_q        <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            host_pend_q  <= host_pend_d;
            auto_pend_q  <= auto_pend_d;
            last_grant_q <= last_grant_d;
            grant_src_q  <= grant_src_d;
            period_cnt_q <= period_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            res_cnt_q    <= res_cnt_d;
            res_sign_q   <= res_sign_d;
            res_src_q    <= res_src_d;
            err_q        <= err_d;
            overrun_q    <= overrun_d;
        end
    end
endmodule

// File: tb/tb_conversion_scheduler.sv
// Directed-plus-random bench for conversion_scheduler; a behavioural sequencer model feeds
// random counts into a scoreboard and timing expectations are derived from cycle arithmetic.
module tb_conversion_scheduler;
    localparam int START_TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conversion_scheduler_if bus ();

    conversion_scheduler #(.START_TO(START_TO), .CONV_TO(65535)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit          seq_en   = 1'b1;
    bit          seq_rand = 1'b1;
    bit          seq_busy = 1'b0;
    int          seq_dly  = 3;
    int          seq_len  = 200;
    logic [11:0] seq_cnt  = 12'd0;
    logic        seq_sgn  = 1'b0;
    logic [12:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outvec();
        return 32'({bus.host_ack_o, bus.conv_trigger_o, bus.result_valid_o, bus.result_o,
                    bus.result_sign_o, bus.result_src_o, bus.overrun_o, bus.err_o});
    endfunction

    // sequencer model: idle falls d cycles after the trigger, rises l cycles later
    initial begin
        int d, l;
        forever begin
            @(negedge clk);
            if (seq_en && !rst && bus.conv_trigger_o) begin
                d = seq_dly;
                l = seq_len;
                seq_busy = 1'b1;
                repeat (d) @(negedge clk);
                bus.idle_i = 1'b0;
                repeat (l) @(negedge clk);
                if (seq_rand) begin
                    seq_cnt = 12'($urandom);
                    seq_sgn = 1'($urandom);
                end
                bus.measurement_count_i = seq_cnt;
                bus.ref_sign_i          = seq_sgn;
                bus.idle_i              = 1'b1;
                exp_q.push_back({seq_sgn, seq_cnt});
                seq_busy = 1'b0;
            end
        end
    end

    // every accepted result must match the oldest finished conversion
    initial begin
        logic [12:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && bus.result_valid_o && bus.result_ready_i) begin
                chk("res_queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("res_value", 32'({bus.result_sign_o, bus.result_o}), 32'(e));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_host(output int c0);
        c0 = cyc;
        bus.host_req_i = 1'b1;
        @(negedge clk);
        bus.host_req_i = 1'b0;
    endtask

    task automatic wait_trig(output int t, output logic ack, input int budget);
        t   = -1;
        ack = 1'bx;
        for (int i = 0; i < budget; i++) begin
            if (bus.conv_trigger_o) begin
                t   = cyc;
                ack = bus.host_ack_o;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_valid(output int v, input int budget);
        v = -1;
        for (int i = 0; i < budget; i++) begin
            if (bus.result_valid_o) begin
                v = cyc;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic count_trig(output int n, input int cycles);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (bus.conv_trigger_o) n++;
            @(negedge clk);
        end
    endtask

    task automatic pulse_clr();
        bus.err_clr_i = 1'b1;
        @(negedge clk);
        bus.err_clr_i = 1'b0;
    endtask

    initial begin
        int   c0, t, v, n, tp, e, nv;
        logic ack;
        bus.host_req_i          = 1'b0;
        bus.auto_en_i           = 1'b0;
        bus.auto_period_i       = 16'd0;
        bus.analog_ready_i      = 1'b1;
        bus.idle_i              = 1'b1;
        bus.ref_sign_i          = 1'b0;
        bus.measurement_count_i = 12'd0;
        bus.result_ready_i      = 1'b0;
        bus.err_clr_i           = 1'b0;

        step(3);
        chk("reset_outputs", outvec(), 32'd0);
        rst = 1'b0;
        step(9);

        // host single shot with a fixed count, readout held until ready
        seq_rand = 1'b0; seq_cnt = 12'h3A5; seq_sgn = 1'b1; seq_dly = 3; seq_len = 200;
        pulse_host(c0);
        wait_trig(t, ack, 20);
        chk("host_trig_cycle", t, c0 + 2);
        chk("host_ack", 32'(ack), 32'd1);
        wait_valid(v, 400);
        chk("host_valid_cycle", v, t + 3 + 200 + 1);
        chk("host_result", 32'({bus.result_src_o, bus.result_sign_o, bus.result_o}),
            32'({1'b0, 1'b1, 12'h3A5}));
        step(5);
        chk("host_valid_held", 32'({bus.result_valid_o, bus.result_o}), 32'({1'b1, 12'h3A5}));
        bus.result_ready_i = 1'b1;
        step(1);
        chk("host_valid_drop", 32'(bus.result_valid_o), 32'd0);

        // random host shots, including a sequencer start at the last allowed cycle
        seq_rand = 1'b1;
        for (int k = 0; k < 6; k++) begin
            seq_dly = (k == 0) ? START_TO - 1 : int'($urandom_range(1, START_TO - 1));
            seq_len = int'($urandom_range(1, 80));
            step(2);
            pulse_host(c0);
            wait_trig(t, ack, 20);
            chk("rand_trig_cycle", t, c0 + 2);
            chk("rand_ack", 32'(ack), 32'd1);
            wait_valid(v, 200);
            chk("rand_valid_cycle", v, t + seq_dly + seq_len + 1);
            chk("rand_src", 32'(bus.result_src_o), 32'd0);
            chk("rand_err", 32'(bus.err_o), 32'd0);
        end

        // periodic auto-sampling, 20-cycle conversions
        seq_dly = 2; seq_len = 18;
        step(2);
        bus.auto_period_i = 16'd100;
        bus.auto_en_i     = 1'b1;
        tp = -1;
        for (int k = 0; k < 4; k++) begin
            wait_trig(t, ack, 150);
            chk("auto_ack", 32'(ack), 32'd0);
            if (k > 0) chk("auto_interval", t - tp, 100);
            tp = t;
            wait_valid(v, 60);
            chk("auto_src", 32'(bus.result_src_o), 32'd1);
        end
        chk("auto_overrun", 32'(bus.overrun_o), 32'd0);
        bus.auto_en_i = 1'b0;
        step(40);

        // round-robin with both pending, fast auto period forcing overrun
        bus.analog_ready_i = 1'b0;
        seq_dly = 2; seq_len = 38;
        bus.auto_period_i = 16'd10;
        bus.auto_en_i     = 1'b1;
        pulse_host(c0);
        count_trig(n, 25);
        chk("rr_gated", n, 0);
        bus.analog_ready_i = 1'b1;
        c0 = cyc;
        wait_trig(t, ack, 10);
        chk("rr_ready_trig", t, c0 + 1);
        chk("rr_first_host", 32'(ack), 32'd1);
        step(5);
        pulse_host(c0);
        wait_trig(t, ack, 80);
        chk("rr_second_auto", 32'(ack), 32'd0);
        wait_trig(t, ack, 80);
        chk("rr_third_host", 32'(ack), 32'd1);
        chk("rr_overrun", 32'(bus.overrun_o), 32'd1);
        bus.auto_en_i = 1'b0;
        step(150);
        pulse_clr();
        chk("ovr_clear", 32'(bus.overrun_o), 32'd0);

        // start timeout: sequencer never leaves idle
        seq_en = 1'b0;
        pulse_host(c0);
        wait_trig(t, ack, 20);
        chk("sto_trig_cycle", t, c0 + 2);
        e = -1; nv = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.err_o) begin
                e = cyc;
                break;
            end
            if (bus.result_valid_o) nv++;
            @(negedge clk);
        end
        // err rises START_TO cycles after the trigger cycle has ended
        chk("sto_err_cycle", e, t + START_TO + 1);
        chk("sto_no_valid", nv, 0);
        seq_en = 1'b1;
        pulse_host(c0);
        wait_trig(t, ack, 20);
        chk("sto_idle_retrig", t, c0 + 2);
        wait_valid(v, 80);
        chk("sto_err_sticky", 32'(bus.err_o), 32'd1);
        pulse_clr();
        chk("sto_err_clear", 32'(bus.err_o), 32'd0);

        // AFE gating then reset during a conversion
        step(3);
        seq_dly = 3; seq_len = 200;
        bus.analog_ready_i = 1'b0;
        pulse_host(c0);
        count_trig(n, 10);
        chk("gate_no_trig", n, 0);
        bus.analog_ready_i = 1'b1;
        c0 = cyc;
        wait_trig(t, ack, 10);
        chk("gate_trig_next", t, c0 + 1);
        step(20);
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", outvec(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        count_trig(n, 50);
        chk("rst_no_retrig", n, 0);
        for (int i = 0; i < 400 && seq_busy; i++) @(negedge clk);
        step(5);
        chk("rst_idle_after", outvec(), 32'd0);
        exp_q.delete();

        seq_dly = 2; seq_len = 10;
        pulse_host(c0);
        wait_trig(t, ack, 20);
        chk("post_rst_trig", t, c0 + 2);
        chk("post_rst_ack", 32'(ack), 32'd1);
        wait_valid(v, 40);
        chk("post_rst_valid", v, t + 2 + 10 + 1);
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
